// File: rtl/ram_rr_arb.sv
// Synchronous RAM shared by NUM_CH requesters through a round-robin arbiter.
// Reads return after READ_LAT clocks; out-of-range accesses raise err.
module ram_rr_arb #(
  parameter int unsigned SIZE     = 1024,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned READ_LAT = 1,
  localparam int unsigned AW      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*AW-1:0]     addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err
);

  localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PW-1:0]       r_ptr;
  logic [NUM_CH-1:0]   w_gnt;
  logic [PW-1:0]       w_gidx;
  logic                w_acc;
  logic [AW-1:0]       w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_we;
  logic                w_oor;

  logic [DATA_W-1:0]   r_mem [SIZE];

  logic [NUM_CH-1:0]   r_s1_vld;
  logic [DATA_W-1:0]   r_s1_data;
  logic                r_s1_err;

  // Two passes: channels above the pointer first, then wrap to the rest.
  always_comb begin
    w_gnt  = '0;
    w_gidx = '0;
    w_acc  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!w_acc && rstN && req[c] && (c > int'(r_ptr))) begin
        w_gnt[c] = 1'b1;
        w_gidx   = PW'(c);
        w_acc    = 1'b1;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!w_acc && rstN && req[c] && (c <= int'(r_ptr))) begin
        w_gnt[c] = 1'b1;
        w_gidx   = PW'(c);
        w_acc    = 1'b1;
      end
    end
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_gnt[c]) begin
        w_addr  = addr[c*AW +: AW];
        w_wdata = wdata[c*DATA_W +: DATA_W];
        w_we    = we[c];
      end
    end
  end

  assign w_oor = ({1'b0, w_addr} >= (AW + 1)'(SIZE));
  assign gnt   = w_gnt;

  always_ff @(posedge clk) begin
    if (w_acc && w_we && !w_oor) begin
      r_mem[w_addr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ptr     <= PW'(NUM_CH - 1);
      r_s1_vld  <= '0;
      r_s1_data <= '0;
      r_s1_err  <= 1'b0;
    end else begin
      r_s1_vld  <= (w_acc && !w_we) ? w_gnt : '0;
      r_s1_data <= (w_acc && !w_we && !w_oor) ? r_mem[w_addr] : '0;
      r_s1_err  <= w_acc && w_oor;
      if (w_acc) begin
        r_ptr <= w_gidx;
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [NUM_CH-1:0] r_s2_vld;
    logic [DATA_W-1:0] r_s2_data;
    logic              r_s2_err;

    always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
        r_s2_vld  <= '0;
        r_s2_data <= '0;
        r_s2_err  <= 1'b0;
      end else begin
        r_s2_vld  <= r_s1_vld;
        r_s2_data <= r_s1_data;
        r_s2_err  <= r_s1_err;
      end
    end

    assign rvalid = r_s2_vld;
    assign rdata  = r_s2_data;
    assign err    = r_s2_err;
  end else begin : g_lat1
    assign rvalid = r_s1_vld;
    assign rdata  = r_s1_data;
    assign err    = r_s1_err;
  end

endmodule

// File: tb/tb_ram_rr_arb.sv
// Bench for ram_rr_arb: a 2-channel latency-1 instance and a 4-channel,
// latency-2, SIZE=1000 instance, checked against a queue of expected returns.
module tb_ram_rr_arb;

  logic clk = 1'b0;
  logic rstN = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         due;
    logic [3:0] rv;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  logic [7:0] mem_a [int];
  logic [7:0] mem_b [int];

  logic [1:0]  a_req = '0, a_we = '0, a_gnt, a_rvalid;
  logic [19:0] a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic [7:0]  a_rdata;
  logic        a_err;

  logic [3:0]  b_req = '0, b_we = '0, b_gnt, b_rvalid;
  logic [39:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic [7:0]  b_rdata;
  logic        b_err;

  ram_rr_arb #(.SIZE(1024), .DATA_W(8), .NUM_CH(2), .READ_LAT(1)) u_a (
    .clk(clk), .rstN(rstN), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata), .err(a_err)
  );

  ram_rr_arb #(.SIZE(1000), .DATA_W(8), .NUM_CH(4), .READ_LAT(2)) u_b (
    .clk(clk), .rstN(rstN), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .err(b_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Output monitors: expected return at its due cycle, all-zero outputs otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      e = qa.pop_front();
      chk("a_return", {19'b0, 2'b0, a_rvalid, a_rdata, a_err}, {19'b0, e.rv, e.data, e.err});
    end else begin
      chk("a_idle", {19'b0, 2'b0, a_rvalid, a_rdata, a_err}, 32'h0);
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      e = qb.pop_front();
      chk("b_return", {19'b0, b_rvalid, b_rdata, b_err}, {19'b0, e.rv, e.data, e.err});
    end else begin
      chk("b_idle", {19'b0, b_rvalid, b_rdata, b_err}, 32'h0);
    end
  end

  task automatic a_drive(input logic [1:0] rq, input logic [1:0] w, input logic [9:0] ad0,
                         input logic [9:0] ad1, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] eg, input string nm);
    exp_t e;
    logic [9:0] adr;
    @(posedge clk);
    #1;
    a_req = rq; a_we = w; a_addr = {ad1, ad0}; a_wdata = {d1, d0};
    #1;
    chk(nm, {30'b0, a_gnt}, {30'b0, eg});
    for (int c = 0; c < 2; c++) begin
      if (eg[c] && rq[c]) begin
        adr = (c == 0) ? ad0 : ad1;
        if (w[c]) begin
          mem_a[int'(adr)] = (c == 0) ? d0 : d1;
        end else begin
          e.due = cyc + 1; e.rv = (c == 0) ? 4'b0001 : 4'b0010;
          e.data = mem_a[int'(adr)]; e.err = 1'b0;
          qa.push_back(e);
        end
      end
    end
  endtask

  task automatic b_drive(input logic [3:0] rq, input logic [3:0] w, input logic [39:0] ad,
                         input logic [31:0] wd, input logic [3:0] eg, input string nm);
    exp_t e;
    int adr;
    @(posedge clk);
    #1;
    b_req = rq; b_we = w; b_addr = ad; b_wdata = wd;
    #1;
    chk(nm, {28'b0, b_gnt}, {28'b0, eg});
    for (int c = 0; c < 4; c++) begin
      if (eg[c] && rq[c]) begin
        adr = int'(ad[c*10 +: 10]);
        e.due = cyc + 2; e.rv = '0; e.data = '0; e.err = (adr >= 1000);
        if (w[c]) begin
          if (adr < 1000) mem_b[adr] = wd[c*8 +: 8];
        end else begin
          e.rv = 4'b0001 << c;
          if (adr < 1000) e.data = mem_b[adr];
        end
        if (!w[c] || e.err) qb.push_back(e);
      end
    end
  endtask

  typedef struct {
    logic [1:0] req, we;
    logic [9:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] gnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b11, 2'b11, 10'h3FF, 10'h3FE, 8'hA5, 8'h5A, 2'b01};
    tbl[1]  = '{2'b11, 2'b11, 10'h100, 10'h3FE, 8'h11, 8'h5A, 2'b10};
    tbl[2]  = '{2'b11, 2'b01, 10'h100, 10'h3FF, 8'h11, 8'h00, 2'b01};
    tbl[3]  = '{2'b10, 2'b00, 10'h000, 10'h3FF, 8'h00, 8'h00, 2'b10};
    tbl[4]  = '{2'b01, 2'b01, 10'h3FF, 10'h3FF, 8'hC3, 8'h00, 2'b01};
    tbl[5]  = '{2'b10, 2'b00, 10'h000, 10'h3FF, 8'h00, 8'h00, 2'b10};
    tbl[6]  = '{2'b11, 2'b00, 10'h100, 10'h3FE, 8'h00, 8'h00, 2'b01};
    tbl[7]  = '{2'b11, 2'b00, 10'h3FE, 10'h3FE, 8'h00, 8'h00, 2'b10};
    tbl[8]  = '{2'b01, 2'b00, 10'h3FE, 10'h000, 8'h00, 8'h00, 2'b01};
    tbl[9]  = '{2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00};
    tbl[10] = '{2'b01, 2'b00, 10'h100, 10'h000, 8'h00, 8'h00, 2'b01};
    tbl[11] = '{2'b01, 2'b00, 10'h3FF, 10'h000, 8'h00, 8'h00, 2'b01};
    tbl[12] = '{2'b11, 2'b00, 10'h3FF, 10'h100, 8'h00, 8'h00, 2'b10};
    tbl[13] = '{2'b01, 2'b00, 10'h3FF, 10'h000, 8'h00, 8'h00, 2'b01};

    #1 rstN = 1'b0;
    a_drive(2'b11, 2'b11, 10'h3FF, 10'h3FE, 8'hA5, 8'h5A, 2'b00, "a_gnt_in_reset");
    b_drive(4'b1111, 4'b0000, 40'h0, 32'h0, 4'b0000, "b_gnt_in_reset");
    a_req = '0; b_req = '0;
    @(posedge clk);
    #1 rstN = 1'b1;

    for (int i = 0; i < 14; i++) begin
      a_drive(tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, tbl[i].gnt,
              $sformatf("a_gnt_vec%0d", i));
    end
    a_drive(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0, 2'b00, "a_gnt_idle");

    // Preload 20..23 with 1..4; the last write from ch3 leaves ch0 next in line.
    b_drive(4'b0001, 4'b0001, {30'd0, 10'd20}, 32'h01, 4'b0001, "b_wr20");
    b_drive(4'b0001, 4'b0001, {30'd0, 10'd21}, 32'h02, 4'b0001, "b_wr21");
    b_drive(4'b0001, 4'b0001, {30'd0, 10'd22}, 32'h03, 4'b0001, "b_wr22");
    b_drive(4'b1000, 4'b1000, {10'd23, 30'd0}, 32'h04000000, 4'b1000, "b_wr23");
    b_drive(4'b1111, 4'b0000, {10'd23, 10'd22, 10'd21, 10'd20}, 32'h0, 4'b0001, "b_rd_c0");
    b_drive(4'b1110, 4'b0000, {10'd23, 10'd22, 10'd21, 10'd20}, 32'h0, 4'b0010, "b_rd_c1");
    b_drive(4'b1100, 4'b0000, {10'd23, 10'd22, 10'd21, 10'd20}, 32'h0, 4'b0100, "b_rd_c2");
    b_drive(4'b1000, 4'b0000, {10'd23, 10'd22, 10'd21, 10'd20}, 32'h0, 4'b1000, "b_rd_c3");

    b_drive(4'b0010, 4'b0010, {20'd0, 10'd1000, 10'd0}, 32'h00005500, 4'b0010, "b_oor_wr");
    b_drive(4'b0100, 4'b0000, {10'd0, 10'd1000, 20'd0}, 32'h0, 4'b0100, "b_oor_rd");
    b_drive(4'b0000, 4'b0000, 40'h0, 32'h0, 4'b0000, "b_gnt_idle");
    b_drive(4'b0000, 4'b0000, 40'h0, 32'h0, 4'b0000, "b_gnt_idle2");

    // Read accepted, then reset lands before its latency-2 return.
    b_drive(4'b0001, 4'b0000, {30'd0, 10'd21}, 32'h0, 4'b0001, "b_rd_before_rst");
    @(posedge clk);
    #1;
    rstN = 1'b0;
    b_req = 4'b1111;
    a_req = 2'b11;
    qa.delete();
    qb.delete();
    #1;
    chk("b_gnt_mid_reset", {28'b0, b_gnt}, 32'h0);
    chk("a_gnt_mid_reset", {30'b0, a_gnt}, 32'h0);
    b_req = '0;
    a_req = '0;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (2) @(posedge clk);

    b_drive(4'b1111, 4'b0000, {10'd20, 10'd23, 10'd22, 10'd21}, 32'h0, 4'b0001, "b_post_c0");
    b_drive(4'b1110, 4'b0000, {10'd20, 10'd23, 10'd22, 10'd21}, 32'h0, 4'b0010, "b_post_c1");
    b_drive(4'b1100, 4'b0000, {10'd20, 10'd23, 10'd22, 10'd21}, 32'h0, 4'b0100, "b_post_c2");
    b_drive(4'b1000, 4'b0000, {10'd20, 10'd23, 10'd22, 10'd21}, 32'h0, 4'b1000, "b_post_c3");
    b_drive(4'b0000, 4'b0000, 40'h0, 32'h0, 4'b0000, "b_gnt_idle3");
    a_drive(2'b11, 2'b00, 10'h3FF, 10'h100, 8'h0, 8'h0, 2'b01, "a_post_c0");
    a_drive(2'b10, 2'b00, 10'h3FF, 10'h100, 8'h0, 8'h0, 2'b10, "a_post_c1");
    a_drive(2'b00, 2'b00, 10'h0, 10'h0, 8'h0, 8'h0, 2'b00, "a_gnt_idle2");

    repeat (5) @(posedge clk);
    #1;
    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_rr_arb.md
Name: ram_rr_arb

Overview:
Parametrised successor to the single-port asynchronous-strobe RAM. It is a synchronous on-chip RAM shared by NUM_CH requesters through a round-robin arbiter. Reads return through a configurable-latency pipeline. Depth, data width, channel count and read latency are all parameters; address width is derived from depth. It sits between bus-side masters (DMA, CPU, peripherals) and the memory array in the top-level design.

Parameters:
SIZE, 1024, number of words; localparam AW = $clog2(SIZE), minimum 1
DATA_W, 8, word width in bits
NUM_CH, 2, number of requesting channels, range 1..8
READ_LAT, 1, read latency in clocks from acceptance edge to rvalid, legal values 1 or 2

Ports:
clk  input  1  clock, all logic rising-edge
rstN  input  1  asynchronous active-low reset
req  input  NUM_CH  per-channel request, held until granted
we  input  NUM_CH  per-channel write enable (1=write, 0=read), qualified by req
addr  input  NUM_CH*AW  per-channel address, channel c at [c*AW +: AW]
wdata  input  NUM_CH*DATA_W  per-channel write data, channel c at [c*DATA_W +: DATA_W]
gnt  output  NUM_CH  one-hot grant, combinational from req and rr pointer
rvalid  output  NUM_CH  one-hot read-data-valid pulse, one per accepted read
rdata  output  DATA_W  shared read data, valid only when any rvalid bit is set
err  output  1  one-cycle pulse READ_LAT cycles after an out-of-range access is accepted

Behaviour:
- Reset is asynchronous and active-low; clock is clk. While rstN=0: gnt=0, rvalid=0, rdata=0, err=0, rr pointer=NUM_CH-1 (so channel 0 has first priority). Memory array is not reset.
- Arbitration: gnt = first set req bit searching upward from (ptr+1) mod NUM_CH with wrap. gnt=0 when req=0. At most one grant per cycle.
- Acceptance = req[c] & gnt[c] at a rising edge. ptr <= c on acceptance; ptr holds otherwise.
- A requester must hold req, we, addr and wdata stable until granted. req may drop after the acceptance edge.
- Write accepted: mem[addr] <= wdata at that edge. No rvalid pulse for writes.
- Read accepted: at edge E, mem[addr] is registered. READ_LAT=1: rvalid[c]=1 and rdata=word in cycle E+1. READ_LAT=2: an extra output register delivers both in cycle E+2.
- rvalid asserts for exactly one cycle per accepted read. When no rvalid bit is set, rdata returns to 0.
- Back-to-back reads (any channels) are accepted every cycle. Throughput is 1 access/clk. Return order equals acceptance order.
- Read after write: a read accepted in the cycle after a write to the same address returns the new data. Same-cycle read/write collisions cannot occur because there is a single grant per cycle.
- Out-of-range: this only applies when SIZE is not a power of 2 and addr >= SIZE. A write is dropped. A read still produces rvalid with rdata=0. err pulses in the same cycle that rvalid would for that access (READ_LAT after acceptance, for writes too).
- Reset mid-operation: in-flight reads are discarded, so no rvalid follows after rstN is released. ptr is restored to NUM_CH-1. Memory contents are preserved.
- NUM_CH=1: the arbiter degenerates to gnt=req.

Test Plan:
- Reset: rstN=0 with req=2'b11 -> gnt=0, rvalid=0, rdata=0, err=0. Release rstN with req=2'b11 -> gnt=2'b01 first, then 2'b10, then 2'b01 (strict alternation).
- Write/read, READ_LAT=1: ch0 writes 8'hA5 to addr 10'h3FF. Next cycle ch1 reads 10'h3FF -> rvalid=2'b10 and rdata=8'hA5 exactly one cycle after the read acceptance.
- READ_LAT=2, NUM_CH=4: reads accepted on four consecutive cycles from ch0..ch3 at addresses holding 1,2,3,4 -> rvalid 0001, 0010, 0100, 1000 with rdata 1,2,3,4 on cycles E+2..E+5, with no gaps.
- Fairness: ch0 holds req continuously while ch1 requests once -> ch1 is granted within 1 cycle of asserting req, and ch0 then resumes.
- Out-of-range, SIZE=1000: write 8'h55 to addr 1000 -> err pulses, memory is unchanged. Read addr 1000 -> rvalid with rdata=0 and err=1 in the same cycle.
- Reset mid-read, READ_LAT=2: assert rstN=0 one cycle after read acceptance -> rvalid and rdata stay 0. After release, re-reading the address returns its pre-reset data.
